// File: rtl/ram_slot_sched.sv
// Fixed-slot time-division scheduler for the shared system RAM.
// CPU, VDG and loader each own a phase of a 16-phase frame; E/Q come from the same frame.
module ram_slot_sched #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_ena,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_rw,
  input  logic              cpu_ram_cs,
  output logic [DATA_W-1:0] cpu_din,
  output logic              e,
  output logic              q,
  output logic [3:0]        phase,
  input  logic              vdg_req,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic [DATA_W-1:0] vdg_data,
  output logic              vdg_valid,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              ld_overflow,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_en,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] PH_VIDEO  = 4'd1;
  localparam logic [3:0] PH_SPARE  = 4'd5;
  localparam logic [3:0] PH_CPU_RD = 4'd9;
  localparam logic [3:0] PH_CPU_WR = 4'd13;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_VID_RD,
    ACC_CPU_RD,
    ACC_CPU_WR,
    ACC_LD_WR
  } acc_t;

  acc_t              acc_sel;   // access chosen for this clk
  acc_t              acc_cur;   // access currently driven on the RAM port
  acc_t              acc_cap;   // read whose data is on ram_rdata now
  logic [3:0]        phase_next;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [DATA_W-1:0] ld_data_q;

  assign phase_next = phase + 4'd1;

  // NOTE: default assignment first keeps this always_comb from inferring a latch.
  always_comb begin
    acc_sel = ACC_NONE;
    if (clk_ena) begin
      case (phase)
        PH_VIDEO: begin
          if (vdg_req)      acc_sel = ACC_VID_RD;
          else if (ld_busy) acc_sel = ACC_LD_WR;
        end
        PH_SPARE: begin
          if (ld_busy) acc_sel = ACC_LD_WR;
        end
        PH_CPU_RD: begin
          if (cpu_ram_cs && cpu_rw) acc_sel = ACC_CPU_RD;
        end
        PH_CPU_WR: begin
          if (cpu_ram_cs && !cpu_rw) acc_sel = ACC_CPU_WR;
        end
        default: acc_sel = ACC_NONE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 4'd0;
      e     <= 1'b0;
      q     <= 1'b0;
    end else if (clk_ena) begin
      phase <= phase_next;
      q     <= (phase_next >= 4'd4) && (phase_next <= 4'd11);
      e     <= phase_next[3];
    end
  end

  // RAM port: one-clk strobes; address/data hold between accesses, reads leave wdata alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      acc_cur   <= ACC_NONE;
    end else begin
      ram_en  <= (acc_sel != ACC_NONE);
      ram_we  <= (acc_sel == ACC_CPU_WR) || (acc_sel == ACC_LD_WR);
      acc_cur <= acc_sel;
      case (acc_sel)
        ACC_VID_RD: ram_addr <= vdg_addr;
        ACC_CPU_RD: ram_addr <= cpu_addr;
        ACC_CPU_WR: begin
          ram_addr  <= cpu_addr;
          ram_wdata <= cpu_dout;
        end
        ACC_LD_WR: begin
          ram_addr  <= ld_addr_q;
          ram_wdata <= ld_data_q;
        end
        default: ;
      endcase
    end
  end

  // Read data is valid the clk after ram_en and is registered at the end of that clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cap   <= ACC_NONE;
      cpu_din   <= '0;
      vdg_data  <= '0;
      vdg_valid <= 1'b0;
    end else begin
      acc_cap   <= acc_cur;
      vdg_valid <= (acc_cap == ACC_VID_RD);
      if (acc_cap == ACC_VID_RD) vdg_data <= ram_rdata;
      if (acc_cap == ACC_CPU_RD) cpu_din  <= ram_rdata;
    end
  end

  // The entry has already been copied to the RAM port during its service clk,
  // so a new write arriving on that clk can safely take the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_busy     <= 1'b0;
      ld_overflow <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
    end else if (ld_wr) begin
      if (!ld_busy || (acc_cur == ACC_LD_WR)) begin
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
        ld_busy   <= 1'b1;
      end else begin
        ld_overflow <= 1'b1;
      end
    end else if (acc_cur == ACC_LD_WR) begin
      ld_busy <= 1'b0;
    end
  end

  // Strobe sanity: writes only with an access, and never two access clks in a row.
  assert property (@(posedge clk) disable iff (reset) ram_we |-> ram_en);
  assert property (@(posedge clk) disable iff (reset) ram_en |=> !ram_en);

endmodule

// File: tb/tb_ram_slot_sched.sv
// Bench for ram_slot_sched: synchronous RAM, transaction-level reference model,
// directed frame/slot scenarios followed by randomized traffic.
module tb_ram_slot_sched;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clk_ena = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_dout = '0;
  logic              cpu_rw = 1'b1;
  logic              cpu_ram_cs = 1'b0;
  logic [DATA_W-1:0] cpu_din;
  logic              e, q;
  logic [3:0]        phase;
  logic              vdg_req = 1'b0;
  logic [ADDR_W-1:0] vdg_addr = '0;
  logic [DATA_W-1:0] vdg_data;
  logic              vdg_valid;
  logic              ld_wr = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_busy, ld_overflow;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_en, ram_we;
  logic [DATA_W-1:0] ram_rdata = '0;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;
  int ena_div  = 0;

  ram_slot_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .clk_ena(clk_ena),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw), .cpu_ram_cs(cpu_ram_cs),
    .cpu_din(cpu_din), .e(e), .q(q), .phase(phase),
    .vdg_req(vdg_req), .vdg_addr(vdg_addr), .vdg_data(vdg_data), .vdg_valid(vdg_valid),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_busy(ld_busy), .ld_overflow(ld_overflow),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // 14.318 MHz enable: every fourth clk.
  initial begin
    forever begin
      @(posedge clk); #1;
      ena_div = (ena_div + 1) % 4;
      clk_ena = (ena_div == 0);
    end
  end

  // Synchronous dual-port style RAM: data appears the clk after ram_en.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Reference model: frame counter plus a list of expected RAM transactions.
  logic [7:0]  ref_mem [0:65535];
  logic [3:0]  m_phase;
  logic        m_e, m_q, m_en, m_we, m_vvalid, m_busy, m_ovf, m_ld_svc, svc_prev;
  logic [15:0] m_addr, m_ld_addr, pw_addr;
  logic [7:0]  m_wdata, m_cdin, m_vdata, m_ld_data, pw_data, cap_val;
  logic        pw_valid;
  int          cap_kind, cap_left;

  initial begin : model
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = '0; m_e = 0; m_q = 0; m_en = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_cdin = '0; m_vdata = '0; m_vvalid = 0;
        m_busy = 0; m_ovf = 0; m_ld_svc = 0; m_ld_addr = '0; m_ld_data = '0;
        cap_kind = 0; cap_left = 0; pw_valid = 0;
      end else begin
        if (pw_valid) ref_mem[pw_addr] = pw_data;
        pw_valid = 0;
        svc_prev = m_ld_svc;
        m_ld_svc = 0;
        m_vvalid = 0;
        if (cap_kind != 0) begin
          cap_left--;
          if (cap_left == 0) begin
            if (cap_kind == 1) begin m_vdata = cap_val; m_vvalid = 1; end
            else m_cdin = cap_val;
            cap_kind = 0;
          end
        end
        m_en = 0; m_we = 0;
        if (clk_ena) begin
          if (m_phase == 4'd1 && vdg_req) begin
            m_en = 1; m_addr = vdg_addr;
            cap_kind = 1; cap_left = 2; cap_val = ref_mem[vdg_addr];
          end else if ((m_phase == 4'd1 || m_phase == 4'd5) && m_busy) begin
            m_en = 1; m_we = 1; m_addr = m_ld_addr; m_wdata = m_ld_data; m_ld_svc = 1;
            pw_valid = 1; pw_addr = m_ld_addr; pw_data = m_ld_data;
          end else if (m_phase == 4'd9 && cpu_ram_cs && cpu_rw) begin
            m_en = 1; m_addr = cpu_addr;
            cap_kind = 2; cap_left = 2; cap_val = ref_mem[cpu_addr];
          end else if (m_phase == 4'd13 && cpu_ram_cs && !cpu_rw) begin
            m_en = 1; m_we = 1; m_addr = cpu_addr; m_wdata = cpu_dout;
            pw_valid = 1; pw_addr = cpu_addr; pw_data = cpu_dout;
          end
          m_phase = m_phase + 4'd1;
          m_q = (m_phase inside {[4'd4:4'd11]});
          m_e = (m_phase >= 4'd8);
        end
        if (ld_wr) begin
          if (!m_busy || svc_prev) begin
            m_ld_addr = ld_addr; m_ld_data = ld_data; m_busy = 1;
          end else begin
            m_ovf = 1;
          end
        end else if (svc_prev) begin
          m_busy = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got no event within budget, required one", name);
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_on && !reset) begin
        check("frame", 64'({phase, e, q}), 64'({m_phase, m_e, m_q}));
        check("ram_port", 64'({ram_en, ram_we, ram_addr, ram_we ? ram_wdata : 8'h00}),
                          64'({m_en, m_we, m_addr, m_we ? m_wdata : 8'h00}));
        check("read_data", 64'({cpu_din, vdg_data, vdg_valid}), 64'({m_cdin, m_vdata, m_vvalid}));
        check("loader", 64'({ld_busy, ld_overflow}), 64'({m_busy, m_ovf}));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_phase(input logic [3:0] p, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (phase == p);
    end
    if (!hit) timeout_fail(name);
  endtask

  task automatic wait_acc(input logic want_we, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = ram_en && (ram_we == want_we);
    end
    if (!hit) timeout_fail(name);
  endtask

  int adv, bad_seq, q_hi, e_hi, both_hi, en_seen, vcnt, vbad;
  logic [3:0] last_ph;

  initial begin : stimulus
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h0600] = 8'h3C; ref_mem[16'h0600] = 8'h3C;
    mem[16'h1234] = 8'h5A; ref_mem[16'h1234] = 8'h5A;

    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_eq", 64'({e, q}), 64'd0);
    check("rst_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'd0);
    check("rst_rdata", 64'({cpu_din, vdg_data, vdg_valid}), 64'd0);
    check("rst_loader", 64'({ld_busy, ld_overflow}), 64'd0);

    // Two idle frames: phase walks 0..15 twice, Q/E follow, RAM stays quiet.
    adv = 0; bad_seq = 0; q_hi = 0; e_hi = 0; both_hi = 0; en_seen = 0; last_ph = phase;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (phase != last_ph) begin
        adv++;
        if (phase != last_ph + 4'd1) bad_seq++;
        last_ph = phase;
      end
      q_hi += int'(q); e_hi += int'(e); both_hi += int'(q && e); en_seen += int'(ram_en);
    end
    check("idle_advances", 64'(adv), 64'd32);
    check("idle_order", 64'(bad_seq), 64'd0);
    check("idle_q_clks", 64'(q_hi), 64'd64);
    check("idle_e_clks", 64'(e_hi), 64'd64);
    check("idle_qe_overlap", 64'(both_hi), 64'd32);
    check("idle_no_ram_en", 64'(en_seen), 64'd0);

    // Reset landing on the CPU read clk cancels the read and the loader entry.
    wait_phase(4'd6, "wait_ph6_a");
    tick(); ld_wr = 1; ld_addr = 16'h0050; ld_data = 8'h99;
    tick(); ld_wr = 0; cpu_addr = 16'h1234; cpu_rw = 1; cpu_ram_cs = 1;
    @(negedge clk);
    check("pre_rst_busy", 64'(ld_busy), 64'd1);
    wait_acc(1'b0, "cpu_rd_for_reset");
    check("pre_rst_rd_addr", 64'(ram_addr), 64'h1234);
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0; cpu_ram_cs = 0;
    @(negedge clk);
    check("midrst_cpu_din", 64'(cpu_din), 64'd0);
    check("midrst_phase", 64'(phase), 64'd0);
    check("midrst_eq", 64'({e, q}), 64'd0);
    check("midrst_busy", 64'(ld_busy), 64'd0);

    // CPU write at phase 13, read back at phase 9 of the next frame.
    tick(); cpu_ram_cs = 1; cpu_rw = 0; cpu_addr = 16'h0400; cpu_dout = 8'hA5;
    wait_acc(1'b1, "cpu_wr");
    check("cpu_wr_port", 64'({ram_addr, ram_wdata}), 64'h0400A5);
    check("cpu_wr_phase", 64'(phase), 64'd14);
    tick(); cpu_rw = 1;
    wait_acc(1'b0, "cpu_rd");
    check("cpu_rd_addr", 64'(ram_addr), 64'h0400);
    @(negedge clk); @(negedge clk);
    check("cpu_rd_data", 64'(cpu_din), 64'hA5);
    tick(); cpu_ram_cs = 0;

    // VDG fetch: one strobe per frame.
    tick(); vdg_req = 1; vdg_addr = 16'h0600;
    vcnt = 0; vbad = 0;
    for (int i = 0; i < 192; i++) begin
      @(negedge clk);
      if (vdg_valid) begin
        vcnt++;
        if (vdg_data != 8'h3C) vbad++;
      end
    end
    check("vdg_pulses", 64'(vcnt), 64'd3);
    check("vdg_data", 64'(vbad), 64'd0);

    // Loader behind a busy video slot goes out in the spare slot.
    wait_phase(4'd15, "wait_ph15");
    tick(); ld_wr = 1; ld_addr = 16'h0010; ld_data = 8'h7E;
    tick(); ld_wr = 0;
    wait_acc(1'b1, "ld_spare");
    check("ld_spare_port", 64'({ram_addr, ram_wdata}), 64'h00107E);
    check("ld_spare_phase", 64'(phase), 64'd6);
    @(negedge clk);
    check("ld_spare_clear", 64'(ld_busy), 64'd0);
    tick(); vdg_req = 0;

    // New loader write on the service clk is accepted without overflow.
    wait_phase(4'd6, "wait_ph6_b");
    tick(); ld_wr = 1; ld_addr = 16'h0020; ld_data = 8'h11;
    tick(); ld_wr = 0;
    wait_acc(1'b1, "ld_svc_a");
    check("ld_svc_a_port", 64'({ram_addr, ram_wdata}), 64'h002011);
    ld_wr = 1; ld_addr = 16'h0021; ld_data = 8'h22;
    @(posedge clk); #1 ld_wr = 0;
    @(negedge clk);
    check("coincident_busy_ovf", 64'({ld_busy, ld_overflow}), 64'b10);
    wait_acc(1'b1, "ld_svc_b");
    check("ld_svc_b_port", 64'({ram_addr, ram_wdata}), 64'h002122);

    // Second write 3 clks after the first is dropped and flagged.
    wait_phase(4'd6, "wait_ph6_c");
    tick(); ld_wr = 1; ld_addr = 16'h0030; ld_data = 8'h33;
    tick(); ld_wr = 0;
    tick();
    tick(); ld_wr = 1; ld_addr = 16'h0031; ld_data = 8'h44;
    tick(); ld_wr = 0;
    @(negedge clk);
    check("overflow_flag", 64'(ld_overflow), 64'd1);
    wait_acc(1'b1, "ld_first_kept");
    check("ld_first_kept", 64'({ram_addr, ram_wdata}), 64'h003033);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      cpu_ram_cs = ($urandom_range(0, 3) != 0);
      cpu_rw     = 1'($urandom_range(0, 1));
      cpu_addr   = 16'h0400 + 16'($urandom_range(0, 15));
      cpu_dout   = 8'($urandom);
      vdg_req    = 1'($urandom_range(0, 1));
      vdg_addr   = 16'h0400 + 16'($urandom_range(0, 31));
      ld_wr      = ($urandom_range(0, 15) == 0);
      ld_addr    = 16'h0400 + 16'($urandom_range(0, 15));
      ld_data    = 8'($urandom);
      if (i == 1500) reset = 1'b1;
      if (i == 1502) reset = 1'b0;
    end
    tick();
    cpu_ram_cs = 0; vdg_req = 0; ld_wr = 0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
